// File: rtl/div_seq_unit_pkg.sv
// Shared divider definitions, also imported by the hazard unit.
package div_seq_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } div_state_t;

    // Fill bit for the divide-by-zero quotient; users replicate it to WIDTH.
    localparam logic DIV_ZERO_QUO = 1'b1;

endpackage

// File: rtl/div_seq_datapath.sv
// Restoring radix-2 divider datapath: magnitude shift registers, trial subtractor,
// iteration counter and sign fix-up into the quotient/remainder output registers.
module div_seq_datapath
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_finish,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_div_zero,
    output logic             o_last,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] r_rem, r_quo, r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg_q, r_neg_r;
    logic [WIDTH-1:0] r_quo_o, r_rem_o;

    logic [WIDTH-1:0] w_abs_a, w_abs_b;
    logic [WIDTH:0]   w_sh, w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx, w_quo_nx, w_fix_q, w_fix_r;

    assign w_abs_a = (i_signed && i_dividend[WIDTH-1]) ? -i_dividend : i_dividend;
    assign w_abs_b = (i_signed && i_divisor[WIDTH-1])  ? -i_divisor  : i_divisor;

    // Partial remainder gets one extra bit so the shifted value cannot overflow.
    assign w_sh     = {r_rem, r_quo[WIDTH-1]};
    assign w_sub    = w_sh - {1'b0, r_dvs};
    assign w_ge     = (w_sh >= {1'b0, r_dvs});
    assign w_rem_nx = w_ge ? w_sub[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    assign w_fix_q = r_neg_q ? -w_quo_nx : w_quo_nx;
    assign w_fix_r = r_neg_r ? -w_rem_nx : w_rem_nx;

    assign o_div_zero  = (i_divisor == '0);
    assign o_last      = (r_cnt == CNT_W'(1));
    assign o_quotient  = r_quo_o;
    assign o_remainder = r_rem_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_cnt   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_quo_o <= '0;
            r_rem_o <= '0;
        end else begin
            if (i_load) begin
                r_rem   <= '0;
                r_quo   <= w_abs_a;
                r_dvs   <= w_abs_b;
                r_cnt   <= CNT_W'(WIDTH);
                r_neg_q <= i_signed & (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]);
                r_neg_r <= i_signed & i_dividend[WIDTH-1];
            end else if (i_step) begin
                r_rem <= w_rem_nx;
                r_quo <= w_quo_nx;
                r_cnt <= r_cnt - CNT_W'(1);
            end
            // Finish together with load is the zero-divisor shortcut from IDLE.
            if (i_finish) begin
                if (i_load) begin
                    r_quo_o <= {WIDTH{DIV_ZERO_QUO}};
                    r_rem_o <= i_dividend;
                end else begin
                    r_quo_o <= w_fix_q;
                    r_rem_o <= w_fix_r;
                end
            end
        end
    end

endmodule

// File: rtl/div_seq_unit.sv
// EX-stage iterative divider: IDLE/BUSY/DONE control with flush, hold and stall
// handling around the restoring datapath.
module div_seq_unit
    import div_seq_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             busy_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_t r_state, w_state_nx;
    logic       w_load, w_step, w_finish, w_div_zero, w_last;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        w_finish   = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_load = 1'b1;
                    if (w_div_zero) begin
                        w_finish   = 1'b1;
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = BUSY;
                    end
                end
            end
            BUSY: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_finish   = 1'b1;
                    w_state_nx = DONE;
                end
            end
            DONE: begin
                if (!hold_i) w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
        // A cancelled instruction must never reach the result registers.
        if (flush_i) begin
            w_state_nx = IDLE;
            w_load     = 1'b0;
            w_step     = 1'b0;
            w_finish   = 1'b0;
        end
    end

    assign stall_o = valid_i & ~flush_i & (r_state != DONE);
    assign done_o  = (r_state == DONE) & ~flush_i;
    assign busy_o  = (r_state == BUSY);

    div_seq_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_finish    (w_finish),
        .i_signed    (signed_i),
        .i_dividend  (dividend_i),
        .i_divisor   (divisor_i),
        .o_div_zero  (w_div_zero),
        .o_last      (w_last),
        .o_quotient  (quotient_o),
        .o_remainder (remainder_o)
    );

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: latency/result model plus directed literal checks.
module tb_div_seq_unit;
    import div_seq_unit_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_i = 1'b0;
    logic         signed_i = 1'b0;
    logic [W-1:0] dividend_i = '0;
    logic [W-1:0] divisor_i = '0;
    logic         flush_i = 1'b0;
    logic         hold_i = 1'b0;
    logic         stall_o, done_o, busy_o;
    logic [W-1:0] quotient_o, remainder_o;

    int asserts = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    div_seq_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_i     (valid_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .stall_o     (stall_o),
        .done_o      (done_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result straight from integer arithmetic (truncating division).
    function automatic logic [2*W-1:0] ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == '0) return {{W{1'b1}}, a};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {q[W-1:0], r[W-1:0]};
    endfunction

    // Model: an accepted divide finishes a fixed number of cycles later.
    bit           m_pend = 1'b0;
    int           m_left = 0;
    logic [W-1:0] m_eq = '0, m_er = '0, m_q = '0, m_r = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_pend = 1'b0;
            m_q    = '0;
            m_r    = '0;
        end else if (flush_i) begin
            m_pend = 1'b0;
        end else begin
            if (!m_pend) begin
                if (valid_i) begin
                    m_pend = 1'b1;
                    m_left = (divisor_i == '0) ? 1 : W + 1;
                    {m_eq, m_er} = ref_div(signed_i, dividend_i, divisor_i);
                end
            end else if (m_left == 0) begin
                if (!hold_i) m_pend = 1'b0;
            end
            if (m_pend && m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_q = m_eq;
                    m_r = m_er;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy_o", busy_o, (m_pend && m_left > 0) ? 1 : 0);
            chk("done_o", done_o, (m_pend && m_left == 0 && !flush_i) ? 1 : 0);
            chk("stall_o", stall_o, (valid_i && !flush_i && !(m_pend && m_left == 0)) ? 1 : 0);
            chk("quotient_o", quotient_o, m_q);
            chk("remainder_o", remainder_o, m_r);
        end
    end

    task automatic wait_done(input int lat, input logic [W-1:0] eq, input logic [W-1:0] er, input string nm);
        int n = 0;
        int st = 0;
        bit ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (stall_o) st++;
            if (done_o) begin
                ok = 1'b1;
                break;
            end
            n++;
        end
        if (!ok) begin
            asserts++;
            fails++;
            $display("FAIL %s_timeout: done_o not seen within 200 cycles, required within %0d", nm, lat);
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_stall_cycles"}, st, lat);
        chk({nm, "_quotient"}, quotient_o, eq);
        chk({nm, "_remainder"}, remainder_o, er);
    endtask

    task automatic run_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input string nm);
        @(posedge clk);
        #1;
        valid_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        wait_done(lat, eq, er, nm);
    endtask

    task automatic idle_cycles(input int n);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = $urandom;
            1: v = W'($urandom_range(0, 15));
            2: v = '0;
            3: v = 32'h8000_0000;
            4: v = '1;
            default: begin
                v = W'($urandom_range(1, 1000));
                if ($urandom_range(0, 1) == 1) v = -v;
            end
        endcase
        return v;
    endfunction

    logic [W-1:0] held_q, held_r;
    int           done_cnt;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk("reset_quotient", quotient_o, 0);
        chk("reset_remainder", remainder_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_stall", stall_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2, "divu_100_7");
        idle_cycles(1);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, "div_m7_2");
        idle_cycles(1);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, "div_intmin_m1");
        run_div(1'b1, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5, "div_5_0");
        idle_cycles(1);

        // Flush in cycle 10 of a DIVU.
        @(posedge clk);
        #1;
        valid_i = 1'b1; signed_i = 1'b0; dividend_i = 32'h0000_FFFF; divisor_i = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        #1;
        chk("flush_idle_busy", busy_o, 0);
        chk("flush_no_done", done_o, 0);
        run_div(1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0, "divu_9_3");
        idle_cycles(1);

        // Hold for 3 cycles from DONE, then back-to-back DIVU.
        run_div(1'b0, 32'd1000, 32'd10, 33, 32'd100, 32'd0, "divu_hold");
        hold_i   = 1'b1;
        held_q   = quotient_o;
        held_r   = remainder_o;
        done_cnt = 1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (k == 2) begin
                hold_i = 1'b0;
                dividend_i = 32'd50;
                divisor_i  = 32'd7;
            end
            @(negedge clk);
            #1;
            if (done_o) done_cnt++;
            chk("hold_quotient_stable", quotient_o, held_q);
            chk("hold_remainder_stable", remainder_o, held_r);
        end
        chk("hold_done_cycles", done_cnt, 4);
        @(posedge clk);
        #1;
        wait_done(33, 32'd7, 32'd1, "divu_b2b");
        idle_cycles(1);

        // Reset in cycle 5 of BUSY with valid_i held high.
        @(posedge clk);
        #1;
        valid_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd12345; divisor_i = 32'd67;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid_quotient", quotient_o, 0);
        chk("rst_mid_remainder", remainder_o, 0);
        chk("rst_mid_busy", busy_o, 0);
        chk("rst_mid_done", done_o, 0);
        wait_done(32, 32'd184, 32'd17, "divu_restart");
        idle_cycles(1);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst        = ($urandom_range(0, 199) == 0);
            flush_i    = ($urandom_range(0, 59) == 0);
            hold_i     = ($urandom_range(0, 2) == 0);
            valid_i    = ($urandom_range(0, 3) != 0);
            signed_i   = $urandom_range(0, 1) == 1;
            dividend_i = pick_operand();
            divisor_i  = pick_operand();
        end
        @(posedge clk);
        #1;
        rst = 1'b0; flush_i = 1'b0; hold_i = 1'b0; valid_i = 1'b0;
        repeat (40) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
